// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// default latencies and the {HI,LO} result pair.
package md_pkg;

    localparam logic [1:0] MD_MULT = 2'b00;
    localparam logic [1:0] MD_DIV  = 2'b01;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/md_compute.sv
// Combinational 32x32 multiply and 32/32 divide, signed or unsigned.
// Division yields {remainder, quotient}; div_zero flags a zero divisor.
module md_compute
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        is_signed,
    output hilo_t       result,
    output logic        div_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod;

    // Signed operations work on magnitudes and fix the signs afterwards, so
    // 0x80000000 / -1 naturally wraps back to 0x80000000 with remainder 0.
    always_comb begin
        div_zero   = (b == 32'd0);
        neg_a      = is_signed & a[31];
        neg_b      = is_signed & b[31];
        mag_a      = neg_a ? -a : a;
        mag_b      = neg_b ? -b : b;
        mag_b_safe = div_zero ? 32'd1 : mag_b;

        quot = mag_a / mag_b_safe;
        rem  = mag_a % mag_b_safe;
        if (neg_a ^ neg_b) begin
            quot = -quot;
        end
        if (neg_a) begin
            rem = -rem;
        end

        prod = {32'd0, mag_a} * {32'd0, mag_b};
        if (neg_a ^ neg_b) begin
            prod = -prod;
        end

        if (op == MD_DIV) begin
            result = {rem, quot};
        end else begin
            result = prod;
        end
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: latches the result at start, holds busy for the
// configured latency, then commits it to HI/LO. Also services mthi/mtlo.
module mdu
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  MDopE,
    input  logic        MDsignE,
    input  logic        HIWriteE,
    input  logic        HISelE,
    input  logic        respon,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    hilo_t            pend;
    logic             pend_ok;
    hilo_t            comp;
    logic             div_zero;
    logic             is_div;
    logic             op_valid;
    logic             accept;
    logic             mt_write;

    md_compute u_compute (
        .a         (rd1E),
        .b         (rd2E),
        .op        (MDopE),
        .is_signed (MDsignE),
        .result    (comp),
        .div_zero  (div_zero)
    );

    assign is_div   = (MDopE == MD_DIV);
    assign op_valid = (MDopE == MD_MULT) | is_div;
    assign busy     = (cnt != '0);
    assign accept   = startE & ~respon & ~busy & op_valid;
    assign mt_write = HIWriteE & ~respon & ~busy;

    // An accepted start takes priority over a same-cycle mthi/mtlo; a zero
    // divisor still runs the full latency but never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend    <= '0;
            pend_ok <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (accept) begin
            pend    <= comp;
            pend_ok <= ~(is_div & div_zero);
            cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if ((cnt == CNT_W'(1)) && pend_ok) begin
                HI <= pend.hi;
                LO <= pend.lo;
            end
        end else if (mt_write) begin
            if (HISelE) begin
                HI <= rd1E;
            end else begin
                LO <= rd1E;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a cycle-indexed reference model compared every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_mdu;
    import md_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [1:0]  MDopE;
    logic        MDsignE;
    logic        HIWriteE;
    logic        HISelE;
    logic        respon;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk      (clk),
        .reset    (reset),
        .startE   (startE),
        .MDopE    (MDopE),
        .MDsignE  (MDsignE),
        .HIWriteE (HIWriteE),
        .HISelE   (HISelE),
        .respon   (respon),
        .rd1E     (rd1E),
        .rd2E     (rd2E),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: busy covers cycles start+1 .. busy_end, and the
    // result lands on the edge that ends cycle busy_end.
    int          cyc      = 0;
    int          busy_end = -1;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    logic [31:0] p_hi     = 32'd0;
    logic [31:0] p_lo     = 32'd0;
    bit          p_ok     = 1'b0;
    bit          cmp_en   = 1'b0;

    task automatic model_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi,
                            output logic [31:0] lo, output bit ok);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        logic [63:0] q;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ok = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        if (op == MD_MULT) begin
            r  = 64'(sa * sb);
            hi = r[63:32];
            lo = r[31:0];
        end else if (b == 32'd0) begin
            ok = 1'b0;
        end else begin
            q  = 64'(sa / sb);
            r  = 64'(sa % sb);
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    always @(posedge clk) begin
        bit bnow;
        if (reset) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            busy_end = -1;
        end else begin
            bnow = (cyc <= busy_end);
            if (cyc == busy_end && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            if ((startE || HIWriteE) && bnow) begin
                errors++;
                $display("FAIL hazard_issue: start=%b hiwrite=%b seen while busy, required none", startE, HIWriteE);
            end
            if (startE && !respon && !bnow && (MDopE == MD_MULT || MDopE == MD_DIV)) begin
                model_op(MDopE, MDsignE, rd1E, rd2E, p_hi, p_lo, p_ok);
                busy_end = cyc + ((MDopE == MD_DIV) ? ND : NM);
            end else if (HIWriteE && !respon && !bnow) begin
                if (HISelE) m_hi = rd1E;
                else        m_lo = rd1E;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", {63'd0, busy}, {63'd0, (cyc <= busy_end)});
            check("cyc_hi", {32'd0, HI}, {32'd0, m_hi});
            check("cyc_lo", {32'd0, LO}, {32'd0, m_lo});
        end
    end

    // Called at a negedge; returns at the first negedge where busy is low.
    task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int n, input bit resp_busy);
        int cnt;
        MDopE   = op;
        MDsignE = sgn;
        rd1E    = a;
        rd2E    = b;
        startE  = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        rd1E   = $urandom;
        rd2E   = $urandom;
        MDopE  = 2'($urandom_range(0, 3));
        cnt    = 0;
        for (int i = 0; i < n + 4; i++) begin
            if (!busy) break;
            cnt++;
            respon = resp_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        respon = 1'b0;
        check("busy_cycles", 64'(cnt), 64'(n));
    endtask

    task automatic mt(input logic sel, input logic [31:0] d, input logic resp);
        HIWriteE = 1'b1;
        HISelE   = sel;
        rd1E     = d;
        respon   = resp;
        @(negedge clk);
        HIWriteE = 1'b0;
        respon   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        startE   = 1'b0;
        MDopE    = MD_MULT;
        MDsignE  = 1'b0;
        HIWriteE = 1'b0;
        HISelE   = 1'b0;
        respon   = 1'b0;
        rd1E     = 32'd0;
        rd2E     = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        run_op(MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, NM, 1'b0);
        check("mult_s_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mult_s_lo", {32'd0, LO}, 64'hFFFF_FFEB);

        run_op(MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, NM, 1'b0);
        check("multu_hi", {32'd0, HI}, 64'h0000_0001);
        check("multu_lo", {32'd0, LO}, 64'hFFFF_FFFE);

        run_op(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, ND, 1'b0);
        check("div_s_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        check("div_s_hi", {32'd0, HI}, 64'hFFFF_FFFF);

        mt(1'b1, 32'h11, 1'b0);
        mt(1'b0, 32'h22, 1'b0);
        check("mthi", {32'd0, HI}, 64'h11);
        check("mtlo", {32'd0, LO}, 64'h22);

        run_op(MD_DIV, 1'b0, 32'h10, 32'd0, ND, 1'b0);
        check("div0_hi", {32'd0, HI}, 64'h11);
        check("div0_lo", {32'd0, LO}, 64'h22);

        // Start cancelled by respon, then a reserved opcode.
        MDopE  = MD_MULT;
        rd1E   = 32'd5;
        rd2E   = 32'd5;
        startE = 1'b1;
        respon = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        respon = 1'b0;
        check("respon_busy", {63'd0, busy}, 64'd0);
        check("respon_hi", {32'd0, HI}, 64'h11);
        MDopE  = 2'b10;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        check("reserved_busy", {63'd0, busy}, 64'd0);

        mt(1'b0, 32'h77, 1'b1);
        check("mtlo_respon", {32'd0, LO}, 64'h22);
        mt(1'b0, 32'h55, 1'b0);
        check("mtlo_55", {32'd0, LO}, 64'h55);

        run_op(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, ND, 1'b1);
        check("div_ovf_lo", {32'd0, LO}, 64'h8000_0000);
        check("div_ovf_hi", {32'd0, HI}, 64'h0);

        run_op(MD_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, ND, 1'b0);
        check("div_pn_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        check("div_pn_hi", {32'd0, HI}, 64'h1);

        run_op(MD_DIV, 1'b0, 32'hFFFF_FFFF, 32'h10, ND, 1'b0);
        check("divu_lo", {32'd0, LO}, 64'h0FFF_FFFF);
        check("divu_hi", {32'd0, HI}, 64'hF);

        run_op(MD_MULT, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, NM, 1'b0);
        check("mult_nn_hi", {32'd0, HI}, 64'h0);
        check("mult_nn_lo", {32'd0, LO}, 64'h1E);

        run_op(MD_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000, NM, 1'b0);
        check("multu_big_hi", {32'd0, HI}, 64'h4000_0000);
        check("multu_big_lo", {32'd0, LO}, 64'h0);

        // Reset during the third busy cycle abandons the multiply.
        MDopE   = MD_MULT;
        MDsignE = 1'b0;
        rd1E    = 32'd3;
        rd2E    = 32'd4;
        startE  = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi", {32'd0, HI}, 64'd0);
        check("rst_mid_lo", {32'd0, LO}, 64'd0);
        repeat (8) @(negedge clk);
        check("rst_late_hi", {32'd0, HI}, 64'd0);
        check("rst_late_lo", {32'd0, LO}, 64'd0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
